// File: rtl/freq_counter.sv
// freq_counter: counts synchronized Fout rising edges over a Gate-cycle window, valid/ack result.
// Build option: define FREQ_COUNTER_SYNC3_EN for a 3-flop synchronizer ahead of the edge detector.
module freq_counter #(
    parameter int CNT_W  = 16,
    parameter int GATE_W = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Fout,
    input  logic              Start,
    input  logic [GATE_W-1:0] Gate,
    input  logic              Ack,
    output logic [CNT_W-1:0]  Count,
    output logic              Valid,
    output logic              Busy,
    output logic              Overflow
);

`ifdef FREQ_COUNTER_SYNC3_EN
    localparam int SYNC_N = 3;
`else
    localparam int SYNC_N = 2;
`endif

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GATE = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [SYNC_N-1:0] sync_q, sync_d;
    logic              prev_q, prev_d;
    logic              rise_s;
    logic [GATE_W-1:0] timer_q, timer_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W:0]    inc_s;
    logic              ovf_q, ovf_d;
    logic              busy_q, busy_d;
    logic              valid_q, valid_d;

    // Returns {saturation_hit, next_value}; the value never wraps.
    function automatic logic [CNT_W:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W:0] r;
        if (v == CNT_MAX) begin
            r = {1'b1, v};
        end else begin
            r = {1'b0, v + CNT_W'(1)};
        end
        return r;
    endfunction

    // Synchronizer shift chain and edge-detect history.
    always_comb begin
        sync_d = {sync_q[SYNC_N-2:0], Fout};
        prev_d = sync_q[SYNC_N-1];
    end

    assign rise_s = sync_q[SYNC_N-1] & ~prev_q;

    // Next-state logic for the measurement FSM, counter and timer.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        inc_s   = sat_inc(cnt_q);
        case (state_q)
            ST_IDLE: begin
                if (Start && (Gate != {GATE_W{1'b0}})) begin
                    state_d = ST_GATE;
                    timer_d = Gate;
                    cnt_d   = {CNT_W{1'b0}};
                    ovf_d   = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GATE: begin
                timer_d = timer_q - GATE_W'(1);
                if (rise_s) begin
                    cnt_d = inc_s[CNT_W-1:0];
                    ovf_d = ovf_q | inc_s[CNT_W];
                end else begin
                    cnt_d = cnt_q;
                    ovf_d = ovf_q;
                end
                // timer==1 marks the final gate cycle; its edge is still counted above.
                if (timer_q == GATE_W'(1)) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_GATE;
                end
            end
            ST_DONE: begin
                if (Ack) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d  = (state_d == ST_GATE);
        valid_d = (state_d == ST_DONE);
    end

    // State and datapath registers.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            sync_q  <= {SYNC_N{1'b0}};
            prev_q  <= 1'b0;
            timer_q <= {GATE_W{1'b0}};
            cnt_q   <= {CNT_W{1'b0}};
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sync_q  <= sync_d;
            prev_q  <= prev_d;
            timer_q <= timer_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
        end
    end

    assign Count    = cnt_q;
    assign Valid    = valid_q;
    assign Busy     = busy_q;
    assign Overflow = ovf_q;

endmodule

// File: tb/tb_freq_counter.sv
// tb_freq_counter: directed bench for freq_counter with a scoreboard of expected window results.
module tb_freq_counter;
    logic        clk = 1'b0;
    logic        reset;
    logic        fout;
    logic        fout_s;
    logic        start;
    logic        ack;
    logic [15:0] gate;
    logic        sel;
    int          fout_mode = 2;

    logic [15:0] count;
    logic        valid, busy, ovf;
    logic [3:0]  count_s;
    logic        valid_s, busy_s, ovf_s;

    logic [15:0] o_count;
    logic        o_valid, o_busy, o_ovf;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int   lo;
        int   hi;
        logic ovf;
        int   lat;
    } exp_t;
    exp_t sb[$];

    logic [15:0] saved;
    int          v_n;
    int          b_n;

    freq_counter #(.CNT_W(16), .GATE_W(16)) dut (
        .Clk(clk), .Reset(reset), .Fout(fout), .Start(start & ~sel), .Gate(gate),
        .Ack(ack & ~sel), .Count(count), .Valid(valid), .Busy(busy), .Overflow(ovf)
    );

    freq_counter #(.CNT_W(4), .GATE_W(16)) dut_s (
        .Clk(clk), .Reset(reset), .Fout(fout_s), .Start(start & sel), .Gate(gate),
        .Ack(ack & sel), .Count(count_s), .Valid(valid_s), .Busy(busy_s), .Overflow(ovf_s)
    );

    assign o_count = sel ? {12'd0, count_s} : count;
    assign o_valid = sel ? valid_s : valid;
    assign o_busy  = sel ? busy_s  : busy;
    assign o_ovf   = sel ? ovf_s   : ovf;

    always #5 clk = ~clk;

    // Fout for the wide instance: period 10 Clk when toggling, else held static.
    initial begin
        fout = 1'b0;
        #3;
        forever begin
            if (fout_mode == 2) begin
                #50;
                fout = ~fout;
            end else begin
                #1;
                fout = (fout_mode == 1);
            end
        end
    end

    // Fout for the 4-bit instance: period 4 Clk.
    initial begin
        fout_s = 1'b0;
        #7;
        forever #20 fout_s = ~fout_s;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_ack();
        ack = 1'b1;
        tick();
        ack = 1'b0;
    endtask

    task automatic run_window(input int g, input int lo, input int hi, input logic ov,
                              input int poke, input string tag);
        exp_t e;
        int   n;
        int   busy_n;
        sb.push_back('{lo, hi, ov, g + 1});
        gate  = g[15:0];
        start = 1'b1;
        tick();
        start  = 1'b0;
        n      = 1;
        busy_n = 0;
        while ((o_valid !== 1'b1) && (n <= g + 8)) begin
            if (o_busy === 1'b1) busy_n++;
            start = (n == poke);
            tick();
            n++;
        end
        start = 1'b0;
        e = sb.pop_front();
        chk({tag, "_latency"}, n, e.lat);
        chk({tag, "_busy_cycles"}, busy_n, g);
        chk({tag, "_valid"}, {31'd0, o_valid}, 32'd1);
        chk({tag, "_busy_done"}, {31'd0, o_busy}, 32'd0);
        chk({tag, "_overflow"}, {31'd0, o_ovf}, {31'd0, e.ovf});
        checks++;
        assert ((int'(o_count) >= e.lo) && (int'(o_count) <= e.hi)) else begin
            errors++;
            $error("FAIL %s_count: observed %0d expected %0d..%0d", tag, o_count, e.lo, e.hi);
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        ack   = 1'b0;
        gate  = 16'd0;
        sel   = 1'b0;
        repeat (3) tick();
        chk("rst_count", {16'd0, o_count}, 32'd0);
        chk("rst_valid", {31'd0, o_valid}, 32'd0);
        chk("rst_busy", {31'd0, o_busy}, 32'd0);
        chk("rst_ovf", {31'd0, o_ovf}, 32'd0);
        reset = 1'b0;
        tick();

        // Reset in the middle of a 1000-cycle window.
        gate  = 16'd1000;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (399) tick();
        chk("mid_busy", {31'd0, o_busy}, 32'd1);
        reset = 1'b1;
        #2;
        reset = 1'b0;
        tick();
        chk("mid_rst_busy", {31'd0, o_busy}, 32'd0);
        chk("mid_rst_valid", {31'd0, o_valid}, 32'd0);
        chk("mid_rst_count", {16'd0, o_count}, 32'd0);
        chk("mid_rst_ovf", {31'd0, o_ovf}, 32'd0);
        tick();

        // Nominal windows.
        run_window(1000, 99, 101, 1'b0, 0, "nom1000");
        do_ack();
        run_window(5000, 499, 501, 1'b0, 0, "nom5000");
        do_ack();

        // Static Fout.
        fout_mode = 0;
        repeat (20) tick();
        run_window(200, 0, 0, 1'b0, 0, "static_lo");
        do_ack();
        fout_mode = 1;
        repeat (20) tick();
        run_window(200, 0, 0, 1'b0, 0, "static_hi");
        do_ack();
        fout_mode = 2;
        repeat (20) tick();

        // Saturation on the 4-bit instance.
        sel = 1'b1;
        tick();
        run_window(100, 15, 15, 1'b1, 0, "sat");
        do_ack();
        run_window(20, 4, 6, 1'b0, 0, "post_sat");
        do_ack();
        sel = 1'b0;
        tick();

        // Start during GATE, then Valid held 50 cycles with Start during DONE.
        run_window(100, 9, 11, 1'b0, 50, "gate_start");
        saved = o_count;
        v_n = 0;
        b_n = 0;
        gate = 16'd20;
        for (int i = 0; i < 50; i++) begin
            start = (i == 10);
            tick();
            if (o_valid === 1'b1) v_n++;
            if (o_busy === 1'b1) b_n++;
        end
        start = 1'b0;
        chk("hold_valid_cycles", v_n, 50);
        chk("hold_busy_cycles", b_n, 0);
        chk("hold_count", {16'd0, o_count}, {16'd0, saved});
        do_ack();
        chk("ack_valid", {31'd0, o_valid}, 32'd0);
        chk("ack_count", {16'd0, o_count}, {16'd0, saved});

        // Start and Ack together in DONE.
        run_window(30, 2, 4, 1'b0, 0, "start_ack");
        saved = o_count;
        gate  = 16'd30;
        start = 1'b1;
        ack   = 1'b1;
        tick();
        start = 1'b0;
        ack   = 1'b0;
        chk("sa_valid", {31'd0, o_valid}, 32'd0);
        chk("sa_busy", {31'd0, o_busy}, 32'd0);
        tick();
        chk("sa_busy_next", {31'd0, o_busy}, 32'd0);
        chk("sa_count", {16'd0, o_count}, {16'd0, saved});

        // Zero gate is ignored.
        gate  = 16'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("zero_busy", {31'd0, o_busy}, 32'd0);
        chk("zero_valid", {31'd0, o_valid}, 32'd0);
        chk("zero_count", {16'd0, o_count}, {16'd0, saved});
        tick();
        chk("zero_busy_next", {31'd0, o_busy}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
